// File: rtl/display_pkg.sv
// Shared character constants and the push-path case folding helper for the display TX path.
package display_pkg;

  localparam int DISP_CHAR_W = 7;

  typedef logic [DISP_CHAR_W-1:0] disp_char_t;

  localparam disp_char_t CHAR_CR    = 7'h0D;
  localparam disp_char_t CHAR_SPACE = 7'h20;
  localparam disp_char_t CHAR_LC_A  = 7'h61;
  localparam disp_char_t CHAR_LC_Z  = 7'h7A;

  // The display font is 6-bit, so lowercase would render as punctuation without folding.
  function automatic disp_char_t fold_case(input disp_char_t c, input bit en);
    if (en && (c >= CHAR_LC_A) && (c <= CHAR_LC_Z)) begin
      return c - CHAR_SPACE;
    end
    return c;
  endfunction

endpackage

// File: rtl/display_tx_fifo_if.sv
// CPU write / display TX handshake bundle; slave is the FIFO, master is the driver side.
interface display_tx_fifo_if;

  logic       flush;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       cpu_busy;
  logic       overflow;
  logic       disp_ready;
  logic       disp_w_en;
  logic       disp_address;
  logic [7:0] disp_din;

  modport slave (
    input  flush, wr_stb, wr_data, disp_ready,
    output cpu_busy, overflow, disp_w_en, disp_address, disp_din
  );

  modport master (
    output flush, wr_stb, wr_data, disp_ready,
    input  cpu_busy, overflow, disp_w_en, disp_address, disp_din
  );

endinterface

// File: rtl/char_fifo_mem.sv
// DEPTH x 7 simple dual-port character store: synchronous write, asynchronous read.
module char_fifo_mem
  import display_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  disp_char_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output disp_char_t        rdata
);

  disp_char_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/display_tx_fifo.sv
// CPU->display character FIFO with registered head output; PB7 busy = full, sticky overflow.
// Define DISPLAY_FIFO_UPCASE_EN to fold a-z to A-Z on push.
module display_tx_fifo
  import display_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  input  logic               pixel_clken,
  input  logic               cpu_clken,
  display_tx_fifo_if.slave   bus
);

`ifdef DISPLAY_FIFO_UPCASE_EN
  localparam bit UPCASE_EN = 1'b1;
`else
  localparam bit UPCASE_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              full;
  logic              wr_attempt;
  logic              push;
  logic              pop;
  logic              out_vld;
  logic              out_vld_nxt;
  logic              busy_q;
  logic              ovf_q;
  disp_char_t        push_char;
  disp_char_t        head_char;
  disp_char_t        out_char;
  disp_char_t        out_char_nxt;
  logic              unused_msb;

  assign unused_msb = bus.wr_data[7];

  assign full       = (count == CNT_FULL);
  assign wr_attempt = cpu_clken & bus.wr_stb;
  assign push       = wr_attempt & ~full;
  // Same qualifier the display uses to sample its TX input.
  assign pop        = pixel_clken & cpu_clken & bus.disp_ready & out_vld;
  assign push_char  = fold_case(bus.wr_data[DISP_CHAR_W-1:0], UPCASE_EN);
  assign rd_ptr_nxt = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;

  char_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (sys_clock),
    .we    (push & ~bus.flush),
    .waddr (wr_ptr),
    .wdata (push_char),
    .raddr (rd_ptr_nxt),
    .rdata (head_char)
  );

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // A push landing in the slot that becomes the head is not yet in memory: bypass it.
  always_comb begin
    out_vld_nxt  = (count_nxt != '0);
    out_char_nxt = '0;
    if (out_vld_nxt) begin
      out_char_nxt = (push && (rd_ptr_nxt == wr_ptr)) ? push_char : head_char;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_vld  <= 1'b0;
      out_char <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_vld  <= 1'b0;
      out_char <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      out_vld  <= out_vld_nxt;
      out_char <= out_char_nxt;
      busy_q   <= (count_nxt == CNT_FULL);
      if (wr_attempt && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.cpu_busy     = busy_q;
  assign bus.overflow     = ovf_q;
  assign bus.disp_w_en    = out_vld;
  assign bus.disp_address = 1'b0;
  assign bus.disp_din     = {1'b0, out_char};

endmodule

// File: tb/tb_display_tx_fifo.sv
// Directed-vector bench for display_tx_fifo with a queue scoreboard and an independent accept monitor.
module tb_display_tx_fifo;
  import display_pkg::*;

  logic sys_clock;
  logic reset_n;
  logic pixel_clken;
  logic cpu_clken;

  display_tx_fifo_if bus();

  display_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .sys_clock   (sys_clock),
    .reset_n     (reset_n),
    .pixel_clken (pixel_clken),
    .cpu_clken   (cpu_clken),
    .bus         (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [6:0] sb[$];

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model of what the FIFO stores for a CPU byte.
  function automatic logic [6:0] exp_char(input logic [7:0] d);
    logic [6:0] c;
    c = d[6:0];
`ifdef DISPLAY_FIFO_UPCASE_EN
    if (c >= 7'h61 && c <= 7'h7A) c = c - 7'h20;
`endif
    return c;
  endfunction

  // Monitor: whatever the display accepts on the coming edge must be the scoreboard head.
  always @(negedge sys_clock) begin
    if (reset_n && pixel_clken && cpu_clken && bus.disp_ready && bus.disp_w_en) begin
      if (sb.size() == 0) begin
        check("unexpected_char", {24'h0, bus.disp_din}, 32'hFFFF_FFFF);
      end else begin
        check("char_order", {24'h0, bus.disp_din}, {25'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_stb  = 1'b1;
    bus.wr_data = d;
    sb.push_back(exp_char(d));
    tick();
    bus.wr_stb  = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.disp_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    tick();
    bus.disp_ready = 1'b0;
    check(name, sb.size(), 0);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset_n        = 1'b0;
    pixel_clken    = 1'b1;
    cpu_clken      = 1'b1;
    bus.flush      = 1'b0;
    bus.wr_stb     = 1'b0;
    bus.wr_data    = 8'h00;
    bus.disp_ready = 1'b0;

    #12;
    check("rst_w_en", bus.disp_w_en, 0);
    check("rst_busy", bus.cpu_busy, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_din", bus.disp_din, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_w_en", bus.disp_w_en, 0);
    check("idle_busy", bus.cpu_busy, 0);
    check("idle_overflow", bus.overflow, 0);
    check("idle_address", bus.disp_address, 0);

    // Single char, bit 7 stripped, held while not accepted
    push(8'hC1);
    check("single_w_en", bus.disp_w_en, 1);
    check("single_din", bus.disp_din, 8'h41);
    pixel_clken    = 1'b0;
    bus.disp_ready = 1'b1;
    repeat (3) tick();
    check("hold_w_en", bus.disp_w_en, 1);
    check("hold_din", bus.disp_din, 8'h41);
    pixel_clken = 1'b1;
    tick();
    bus.disp_ready = 1'b0;
    check("single_done_w_en", bus.disp_w_en, 0);

    // Burst to full, dropped 17th push
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      d = 8'h40 + 8'(i);
      if (i % 2 == 1) d[7] = 1'b1;
      push(d);
      if (i == 14) check("busy_at_15", bus.cpu_busy, 0);
    end
    check("full_busy", bus.cpu_busy, 1);
    check("full_overflow_pre", bus.overflow, 0);
    bus.wr_stb  = 1'b1;
    bus.wr_data = 8'h5A;
    tick();
    bus.wr_stb  = 1'b0;
    check("drop_overflow", bus.overflow, 1);
    check("drop_busy", bus.cpu_busy, 1);
    drain("burst_drain");
    check("burst_busy_after", bus.cpu_busy, 0);
    check("overflow_sticky", bus.overflow, 1);
    check("burst_w_en_after", bus.disp_w_en, 0);

    do_flush();
    check("flush_clears_ovf", bus.overflow, 0);

    // Simultaneous push and accept at count 5
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    bus.wr_stb     = 1'b1;
    bus.wr_data    = 8'h35;
    bus.disp_ready = 1'b1;
    sb.push_back(exp_char(8'h35));
    tick();
    bus.wr_stb     = 1'b0;
    bus.disp_ready = 1'b0;
    check("simul_count", dut.count, 5);
    check("simul_head", bus.disp_din, 8'h31);
    for (int i = 0; i < 11; i++) push(8'h50 + 8'(i));
    check("simul_full_busy", bus.cpu_busy, 1);
    bus.wr_stb     = 1'b1;
    bus.wr_data    = 8'h7E;
    bus.disp_ready = 1'b1;
    tick();
    bus.wr_stb     = 1'b0;
    bus.disp_ready = 1'b0;
    check("full_simul_ovf", bus.overflow, 1);
    check("full_simul_count", dut.count, 15);
    check("full_simul_busy", bus.cpu_busy, 0);
    check("full_simul_head", bus.disp_din, 8'h32);
    drain("simul_drain");

    // Flush with a concurrent push
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    bus.flush   = 1'b1;
    bus.wr_stb  = 1'b1;
    bus.wr_data = 8'h42;
    tick();
    bus.flush  = 1'b0;
    bus.wr_stb = 1'b0;
    sb.delete();
    check("flush_w_en", bus.disp_w_en, 0);
    check("flush_ovf", bus.overflow, 0);
    check("flush_busy", bus.cpu_busy, 0);
    push(8'h43);
    check("post_flush_w_en", bus.disp_w_en, 1);
    check("post_flush_head", bus.disp_din, 8'h43);
    drain("flush_drain");

    // Case folding and control codes
    push(8'h61);
`ifdef DISPLAY_FIFO_UPCASE_EN
    check("case_a", bus.disp_din, 8'h41);
`else
    check("case_a", bus.disp_din, 8'h61);
`endif
    push({1'b1, CHAR_CR});
    push(8'h7A);
    push(8'h7B);
    push(8'h60);
    drain("case_drain");
    push(8'h0D);
    check("cr_passthrough", bus.disp_din, 8'h0D);
    drain("cr_drain");

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) push(8'h44 + 8'(i));
    reset_n = 1'b0;
    #2;
    check("arst_w_en", bus.disp_w_en, 0);
    check("arst_count", dut.count, 0);
    check("arst_din", bus.disp_din, 0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("arst_idle_w_en", bus.disp_w_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
